// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per ADD/SHIFT pair.
// Optional `MULT_ZERO_SKIP_EN: a zero operand completes straight from IDLE in one cycle.
module shift_add_multiplier #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           go,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]   mcand_q, mcand_d;
    logic [N:0]     acc_q, acc_d;
    logic [N-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;

    logic [CW-1:0]  cnt_inc;
    logic           last;
    logic [2*N:0]   shifted;
    logic           zero_op;

    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        last    = (cnt_inc == CW'(N));
        shifted = {acc_q, mplr_q} >> 1;
    end

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = zero_op ? S_DONE : S_ADD;
                end
            end
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = last ? S_DONE : S_ADD;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done    = (state_q == S_DONE);
        busy    = (state_q != S_IDLE);
        product = product_q;
    end

    // Datapath next-state: {acc, mplr} acts as one 2N+1 bit shift register.
    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    mcand_d = multiplicand;
                    mplr_d  = multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (zero_op) begin
                        product_d = '0;
                    end
                end
            end
            S_ADD: begin
                if (mplr_q[0]) begin
                    acc_d = {1'b0, acc_q[N-1:0]} + {1'b0, mcand_q};
                end
            end
            S_SHIFT: begin
                acc_d  = shifted[2*N:N];
                mplr_d = shifted[N-1:0];
                cnt_d  = cnt_inc;
                if (last) begin
                    product_d = shifted[2*N-1:0];
                end
            end
            S_DONE: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-and-add multiplier for the Lab 6 arithmetic datapath. It is the inverse-direction companion to the restoring divider. It accepts two N-bit operands on a `go` pulse and iterates one multiplier bit per ADD/SHIFT cycle pair. It then presents a 2N-bit product with a one-cycle `done` strobe. The block is built as a control FSM driving a datapath (accumulator, multiplier shift register, multiplicand register, product register).

## Interface

Parameters:
- `N`, default 4: operand width. Legal for N >= 2. Product width is 2N.

Ports:
- `clk` in 1: clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `go` in 1: start request. Sampled only in IDLE.
- `multiplicand` in N: operand A. Captured when `go` is accepted.
- `multiplier` in N: operand B. Captured when `go` is accepted.
- `product` out 2N: registered result. Holds until the next completion.
- `done` out 1: high for exactly one cycle while in DONE.
- `busy` out 1: high in every state except IDLE.

## Operation

- **States:** IDLE, ADD, SHIFT, DONE. State is registered and reset to IDLE.
- **Internal registers:**
  - `mcand`: N bits.
  - `acc`: N+1 bits, top bit is the carry.
  - `mplr`: N bits.
  - `cnt`: ceil(log2(N+1)) bits.
- **IDLE**
  - If `go`=1 on an edge: load `mcand`=multiplicand, `mplr`=multiplier, `acc`=0, `cnt`=0, then go to ADD.
  - Otherwise stay in IDLE.
- **ADD**
  - If `mplr[0]`=1: `acc` <= `acc[N-1:0]` + `mcand`. The sum is N+1 bits and the carry lands in `acc[N]`.
  - Otherwise `acc` is unchanged.
  - Always go to SHIFT.
- **SHIFT**
  - Logical right shift of the concatenation {`acc`, `mplr`} by one, with 0 entering at the MSB.
  - `cnt` <= `cnt` + 1.
  - If the incremented `cnt` equals N: load `product` <= {`acc[N-1:0]`, `mplr`} after the shift, and go to DONE.
  - Otherwise go back to ADD.
- **DONE**
  - `done`=1 for this one cycle, then go unconditionally to IDLE.
  - `go` is ignored in DONE.
- **go while busy:** ignored. Operand inputs may change freely after acceptance.
- **Arithmetic:** unsigned, no overflow is possible. After the final shift `acc[N]` is always 0.
- **Reset**
  - Values: `product`=0, `done`=0, `busy`=0, state=IDLE, all internal registers 0.
  - Reset mid-operation aborts the multiply. `product` is cleared and no `done` is generated.

## Timing

- **Edge numbering:** edge E0 is the edge that samples `go`=1 in IDLE.
- **ADD/SHIFT sequence:** ADD is evaluated at odd edges E1, E3, … E(2N-1). SHIFT is evaluated at even edges E2 … E2N.
- **Completion:** `product` is updated at E2N. `done`=1 and `product` are valid in the cycle between E2N and E2N+1.
- **Latency:** 2N cycles from the accepting edge to `done`. Throughput is one operation per 2N+2 cycles if `go` is held high.
- **busy:** rises in the cycle after E0 and falls in the cycle after E2N+1. `done` and `busy` are both high during DONE.
- **Outputs:** `done` and `busy` are decoded from the state register (glitch-free, registered state). `product` is a register.
- **Simultaneous events:** `resetn`=0 on the same edge as a `go` acceptance wins. The block stays in IDLE.

## Configuration

- **`MULT_ZERO_SKIP_EN` defined**
  - In IDLE, if `go`=1 and either operand is 0 on the accepting edge: load `product`=0 at E0 and go directly to DONE.
  - `done` is then high in the cycle between E0 and E1, giving a latency of 1 cycle.
  - Nonzero operands behave exactly as in the non-skip path.
- **`MULT_ZERO_SKIP_EN` undefined**
  - Zero operands take the full 2N-cycle path and yield `product`=0.

## Test plan

All scenarios use N=4.

- **Reset:** hold `resetn`=0 for 2 cycles, then release.
  - `product`=0x00, `done`=0, `busy`=0.
  - `go`=0 for 10 cycles leaves all outputs unchanged.
- **Full-scale and small operands:**
  - 15×15, `go` pulse at E0: `product`=0xE1 (225) with `done`=1 exactly at E8→E9 and `busy`=1 over E0→E9.
  - 3×5 then gives 0x0F.
- **Carry path:**
  - 8×15 gives 0x78.
  - 9×9 gives 0x51.
  - Checks `acc[N]` carry handling.
- **Zero operand:** 0×7.
  - Undefined macro: `product`=0x00, `done` at E8.
  - `MULT_ZERO_SKIP_EN`: `done` at E0→E1, `busy` high for 1 cycle.
- **Busy lockout:**
  - 6×7 accepted. Pulse `go` with 2×2 at E3 and E8: ignored, result 0x2A.
  - `go` held high continuously: back-to-back results with `done` every 10 cycles.
- **Abort:**
  - Start 13×11, assert `resetn`=0 at E5: `product`=0, no `done`.
  - Next 13×11 gives 0x8F.
